fpu_ss_result_wb: RTL

//  Write-back collector for integer-destination results of the FPU subsystem.

---
 rtl/fpu_ss_pkg.sv | 17 +
 rtl/fpu_ss_result_fifo.sv | 54 +++++
 rtl/fpu_ss_result_wb.sv | 105 ++++++++++
 3 files changed

// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the FPU subsystem integer write-back path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fpu_ss_pkg;

  localparam int FPU_SS_RESULT_DEPTH = 4;
  localparam int FPU_SS_ID_WIDTH     = 4;

  // One integer-destination result as handed to the core.
  typedef struct packed {
    logic [FPU_SS_ID_WIDTH-1:0] id;
    logic [4:0]                 rd;
    logic [31:0]                data;
    logic                       we;
  } fpu_ss_result_t;

endpackage

// File: rtl/fpu_ss_result_fifo.sv
// Dual-write, single-read circular FIFO; port 0 is the older write when both fire.
// Latency: 1 cycle from write to visibility at head_o.
// Backpressure: none internally; the caller must never overfill (count_o is exported for that).
module fpu_ss_result_fifo
  import fpu_ss_pkg::*;
#(
  parameter int  DEPTH = FPU_SS_RESULT_DEPTH,
  parameter type T     = fpu_ss_result_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push0_i,
  input  T                         push0_dat_i,
  input  logic                     push1_i,
  input  T                         push1_dat_i,
  input  logic                     pop_i,
  output T                         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW-1:0]   wr1_idx;
  logic [CW-1:0]   count;

  // Second write lands just after the first when both fire, otherwise at wptr.
  assign wr1_idx = wptr + AW'(push0_i);
  assign head_o  = mem[rptr];
  assign count_o = count;

  // Storage array; contents are don't-care while not counted, so no reset.
  always_ff @(posedge clk_i) begin
    if (push0_i) mem[wptr]    <= push0_dat_i;
    if (push1_i) mem[wr1_idx] <= push1_dat_i;
  end

  // Pointers wrap naturally modulo DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(push0_i) + AW'(push1_i);
      rptr  <= rptr + AW'(pop_i);
      count <= count + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
    end
  end

endmodule

// File: rtl/fpu_ss_result_wb.sv
// Collects CSR reads and integer FPU results in order and presents them to the core result port.
// Latency: 1 cycle push-to-valid; 0 cycles from an empty queue when FPU_SS_RESULT_BYPASS_EN is defined.
// Backpressure: ready derives from registered occupancy only; CSR takes a slot before FPU in the same cycle.
module fpu_ss_result_wb
  import fpu_ss_pkg::*;
#(
  parameter int DEPTH    = FPU_SS_RESULT_DEPTH,
  parameter int ID_WIDTH = FPU_SS_ID_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                csr_wb_i,
  input  logic [ID_WIDTH-1:0] csr_id_i,
  input  logic [4:0]          csr_rd_i,
  input  logic [31:0]         csr_rdata_i,
  output logic                csr_ready_o,
  input  logic                fpu_wb_i,
  input  logic [ID_WIDTH-1:0] fpu_id_i,
  input  logic [4:0]          fpu_rd_i,
  input  logic [31:0]         fpu_rdata_i,
  output logic                fpu_ready_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic [31:0]         result_data_o,
  output logic                result_we_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [4:0]          rd;
    logic [31:0]         data;
    logic                we;
  } entry_t;

  entry_t          csr_e;
  entry_t          fpu_e;
  entry_t          head;
  entry_t          out_e;
  logic [CW-1:0]   count;
  logic [CW-1:0]   free;
  logic            csr_acc;
  logic            fpu_acc;
  logic            push0;
  logic            push1;
  logic            pop;
  logic            empty;

  assign csr_e = '{id: csr_id_i, rd: csr_rd_i, data: csr_rdata_i, we: (csr_rd_i != 5'd0)};
  assign fpu_e = '{id: fpu_id_i, rd: fpu_rd_i, data: fpu_rdata_i, we: (fpu_rd_i != 5'd0)};

  assign empty = (count == '0);
  assign free  = CW'(DEPTH) - count;

  // A same-cycle CSR result claims a slot first, so FPU then needs two free.
  assign csr_ready_o = (free >= CW'(1));
  assign fpu_ready_o = csr_wb_i ? (free >= CW'(2)) : (free >= CW'(1));
  assign csr_acc     = csr_wb_i & csr_ready_o;
  assign fpu_acc     = fpu_wb_i & fpu_ready_o;
  assign pop         = ~empty & result_ready_i;

  // Route accepted results into the queue (or straight out) and select the head to present.
  always_comb begin
    push0          = csr_acc;
    push1          = fpu_acc;
    result_valid_o = ~empty;
    out_e          = empty ? '0 : head;
`ifdef FPU_SS_RESULT_BYPASS_EN
    if (empty) begin
      result_valid_o = csr_wb_i | fpu_wb_i;
      if (csr_wb_i)      out_e = csr_e;
      else if (fpu_wb_i) out_e = fpu_e;
      // Oldest incoming entry leaves immediately; only the younger one is stored.
      if (result_ready_i) begin
        if (csr_wb_i) push0 = 1'b0;
        else          push1 = 1'b0;
      end
    end
`endif
  end

  assign result_id_o   = out_e.id;
  assign result_rd_o   = out_e.rd;
  assign result_data_o = out_e.data;
  assign result_we_o   = out_e.we;

  fpu_ss_result_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push0_i     (push0),
    .push0_dat_i (csr_e),
    .push1_i     (push1),
    .push1_dat_i (fpu_e),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

endmodule
